// File: rtl/apb_seq_pkg.sv
// Shared types and APB slave map for the round-robin APB sequencer.
// Holds the FSM state encoding and the 3-slot slave address decode.
package apb_seq_pkg;

   localparam int PSW = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP
   } state_t;

   localparam logic [31:0] S0_BASE = 32'h8000_0000;
   localparam logic [31:0] S0_LIM  = 32'h83FF_FFFF;
   localparam logic [31:0] S1_BASE = 32'h8400_0000;
   localparam logic [31:0] S1_LIM  = 32'h87FF_FFFF;
   localparam logic [31:0] S2_BASE = 32'h8800_0000;
   localparam logic [31:0] S2_LIM  = 32'h8BFF_FFFF;

   function automatic logic [PSW-1:0] decode(input logic [31:0] a);
      logic [PSW-1:0] s;
      s = '0;
      if (a >= S0_BASE && a <= S0_LIM) s = 3'b001;
      else if (a >= S1_BASE && a <= S1_LIM) s = 3'b010;
      else if (a >= S2_BASE && a <= S2_LIM) s = 3'b100;
      return s;
   endfunction

endpackage

// File: rtl/apb_rr_sequencer_rr_pick.sv
// Round-robin priority picker: first asserted request at or after ptr,
// wrapping, returned as one-hot grant plus its binary index.
module rr_pick #(
   parameter int N  = 2,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] idx,
   output logic          any
);

   always_comb begin
      logic [PW:0]   sum;
      logic [PW-1:0] cand;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, ptr} + (PW+1)'(i);
         if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
         cand = sum[PW-1:0];
         if (!any && req[cand]) begin
            grant[cand] = 1'b1;
            idx         = cand;
            any         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_rr_sequencer.sv
// Shares one APB master port between NREQ valid/ready requesters,
// round-robin arbitrated, one transfer in flight at a time.
module apb_rr_sequencer
   import apb_seq_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              Hclk,
   input  logic              Hreset,
   input  logic [NREQ-1:0]   Req_valid,
   input  logic [NREQ-1:0]   Req_write,
   input  logic [NREQ*AW-1:0] Req_addr,
   input  logic [NREQ*DW-1:0] Req_wdata,
   output logic [NREQ-1:0]   Req_ready,
   output logic [NREQ-1:0]   Rsp_valid,
   output logic [DW-1:0]     Rsp_rdata,
   output logic              Rsp_err,
   output logic [PSW-1:0]    Pselx,
   output logic [AW-1:0]     Paddr,
   output logic              Pwrite,
   output logic              Penable,
   output logic [DW-1:0]     Pwdata,
   input  logic              Pready,
   input  logic [DW-1:0]     Prdata,
   input  logic              Pslverr
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT);

   state_t         state_q;
   state_t         state_n;
   logic [PW-1:0]  ptr_q;
   logic [PW-1:0]  ptr_nxt;
   logic [NREQ-1:0] owner_q;
   logic [AW-1:0]  addr_q;
   logic [DW-1:0]  wdata_q;
   logic           write_q;
   logic [PSW-1:0] sel_q;
   logic [CW-1:0]  cnt_q;
   logic [PSW-1:0] psel_q;
   logic [PSW-1:0] psel_d;
   logic           pen_q;
   logic           pen_d;
   logic [NREQ-1:0] rsp_valid_q;
   logic [NREQ-1:0] rsp_valid_d;
   logic [DW-1:0]  rsp_rdata_q;
   logic [DW-1:0]  rsp_rdata_d;
   logic           rsp_err_q;
   logic           rsp_err_d;

   logic [NREQ-1:0] grant;
   logic [PW-1:0]  gidx;
   logic           any;
   logic [AW-1:0]  sel_addr;
   logic [DW-1:0]  sel_wdata;
   logic           sel_write;
   logic [PSW-1:0] dec;
   logic           accept;
   logic           tmo;

   rr_pick #(
      .N  (NREQ),
      .PW (PW)
   ) u_pick (
      .req   (Req_valid),
      .ptr   (ptr_q),
      .grant (grant),
      .idx   (gidx),
      .any   (any)
   );

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_write = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_addr  |= Req_addr[i*AW +: AW];
            sel_wdata |= Req_wdata[i*DW +: DW];
            sel_write |= Req_write[i];
         end
      end
   end

   assign dec     = decode(32'(sel_addr));
   assign accept  = (state_q == ST_IDLE) && any && !Hreset;
   assign tmo     = (cnt_q == CW'(TIMEOUT - 1));
   assign ptr_nxt = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);

   always_comb begin
      state_n     = state_q;
      Req_ready   = '0;
      rsp_valid_d = '0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               Req_ready = grant;
               if (dec != '0) begin
                  state_n = ST_SETUP;
               end else begin
                  state_n     = ST_RESP;
                  rsp_valid_d = grant;
                  rsp_err_d   = 1'b1;
               end
            end
         end
         ST_SETUP: state_n = ST_ACCESS;
         ST_ACCESS: begin
            if (Pready) begin
               state_n     = ST_RESP;
               rsp_valid_d = owner_q;
               rsp_err_d   = Pslverr;
               rsp_rdata_d = write_q ? '0 : Prdata;
            end else if (tmo) begin
               state_n     = ST_RESP;
               rsp_valid_d = owner_q;
               rsp_err_d   = 1'b1;
            end
         end
         ST_RESP: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // SETUP is only ever entered straight from an accept, so dec is live then
   always_comb begin
      psel_d = '0;
      if (state_n == ST_SETUP) psel_d = dec;
      else if (state_n == ST_ACCESS) psel_d = sel_q;
      pen_d = (state_n == ST_ACCESS);
   end

   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         write_q     <= 1'b0;
         sel_q       <= '0;
         cnt_q       <= '0;
         psel_q      <= '0;
         pen_q       <= 1'b0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_n;
         psel_q      <= psel_d;
         pen_q       <= pen_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         if (accept) begin
            owner_q <= grant;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            write_q <= sel_write;
            sel_q   <= dec;
            ptr_q   <= ptr_nxt;
         end
         if (state_q == ST_SETUP)
            cnt_q <= '0;
         else if (state_q == ST_ACCESS && !Pready && !tmo)
            cnt_q <= cnt_q + CW'(1);
      end
   end

   assign Pselx     = psel_q;
   assign Penable   = pen_q;
   assign Paddr     = addr_q;
   assign Pwrite    = write_q;
   assign Pwdata    = wdata_q;
   assign Rsp_valid = rsp_valid_q;
   assign Rsp_rdata = rsp_rdata_q;
   assign Rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_rr_sequencer.sv
// Directed bench for apb_rr_sequencer: arbitration, APB phasing,
// wait states, decode miss, timeout, slave error and mid-transfer reset.
module tb_apb_rr_sequencer;

   localparam int NREQ = 2;
   localparam int AW   = 32;
   localparam int DW   = 32;

   logic              Hclk = 1'b0;
   logic              Hreset;
   logic [NREQ-1:0]   Req_valid;
   logic [NREQ-1:0]   Req_write;
   logic [NREQ*AW-1:0] Req_addr;
   logic [NREQ*DW-1:0] Req_wdata;
   logic [NREQ-1:0]   Req_ready;
   logic [NREQ-1:0]   Rsp_valid;
   logic [DW-1:0]     Rsp_rdata;
   logic              Rsp_err;
   logic [2:0]        Pselx;
   logic [AW-1:0]     Paddr;
   logic              Pwrite;
   logic              Penable;
   logic [DW-1:0]     Pwdata;
   logic              Pready;
   logic [DW-1:0]     Prdata;
   logic              Pslverr;

   int total = 0;
   int bad   = 0;

   apb_rr_sequencer #(
      .NREQ    (NREQ),
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (16)
   ) dut (
      .Hclk      (Hclk),
      .Hreset    (Hreset),
      .Req_valid (Req_valid),
      .Req_write (Req_write),
      .Req_addr  (Req_addr),
      .Req_wdata (Req_wdata),
      .Req_ready (Req_ready),
      .Rsp_valid (Rsp_valid),
      .Rsp_rdata (Rsp_rdata),
      .Rsp_err   (Rsp_err),
      .Pselx     (Pselx),
      .Paddr     (Paddr),
      .Pwrite    (Pwrite),
      .Penable   (Penable),
      .Pwdata    (Pwdata),
      .Pready    (Pready),
      .Prdata    (Prdata),
      .Pslverr   (Pslverr)
   );

   always #5 Hclk = ~Hclk;

   task automatic tick();
      @(posedge Hclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
      Req_valid[i]          = v;
      Req_write[i]          = w;
      Req_addr[i*AW +: AW]  = a;
      Req_wdata[i*DW +: DW] = d;
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, "_psel"}, 32'(Pselx), 32'h0);
      chk({tag, "_pen"}, 32'(Penable), 32'h0);
      chk({tag, "_paddr"}, Paddr, 32'h0);
      chk({tag, "_pwrite"}, 32'(Pwrite), 32'h0);
      chk({tag, "_pwdata"}, Pwdata, 32'h0);
      chk({tag, "_rspv"}, 32'(Rsp_valid), 32'h0);
      chk({tag, "_rdata"}, Rsp_rdata, 32'h0);
      chk({tag, "_err"}, 32'(Rsp_err), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int own;
      Hreset    = 1'b1;
      Req_valid = '0;
      Req_write = '0;
      Req_addr  = '0;
      Req_wdata = '0;
      Pready    = 1'b0;
      Prdata    = '0;
      Pslverr   = 1'b0;
      tick();
      tick();
      chk_idle_outs("rst");
      chk("rst_ready", 32'(Req_ready), 32'h0);
      Hreset = 1'b0;

      // single zero-wait read from req0
      set_req(0, 1'b1, 1'b0, 32'h8000_0010, 32'h0);
      #1;
      chk("t1_ready", 32'(Req_ready), 32'h1);
      tick();
      Req_valid = '0;
      Pready    = 1'b1;
      Prdata    = 32'hDEAD_BEEF;
      chk("t1_setup_psel", 32'(Pselx), 32'h1);
      chk("t1_setup_pen", 32'(Penable), 32'h0);
      chk("t1_setup_paddr", Paddr, 32'h8000_0010);
      chk("t1_setup_rspv", 32'(Rsp_valid), 32'h0);
      tick();
      chk("t1_acc_psel", 32'(Pselx), 32'h1);
      chk("t1_acc_pen", 32'(Penable), 32'h1);
      chk("t1_acc_pwrite", 32'(Pwrite), 32'h0);
      tick();
      Pready = 1'b0;
      chk("t1_rspv", 32'(Rsp_valid), 32'h1);
      chk("t1_rdata", Rsp_rdata, 32'hDEAD_BEEF);
      chk("t1_err", 32'(Rsp_err), 32'h0);
      chk("t1_resp_psel", 32'(Pselx), 32'h0);
      chk("t1_resp_pen", 32'(Penable), 32'h0);
      tick();
      chk("t1_idle_rspv", 32'(Rsp_valid), 32'h0);

      // reset returns pointer to 0, then both requesters write continuously
      Hreset = 1'b1;
      tick();
      Hreset = 1'b0;
      set_req(0, 1'b1, 1'b1, 32'h8400_0000, 32'h1111_0000);
      set_req(1, 1'b1, 1'b1, 32'h8400_0000, 32'h2222_0001);
      Pready = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         own = k % 2;
         chk("t2_ready", 32'(Req_ready), 32'(1 << own));
         tick();
         chk("t2_psel", 32'(Pselx), 32'h2);
         chk("t2_pwrite", 32'(Pwrite), 32'h1);
         chk("t2_pwdata", Pwdata, (own == 0) ? 32'h1111_0000 : 32'h2222_0001);
         chk("t2_setup_pen", 32'(Penable), 32'h0);
         tick();
         chk("t2_acc_pen", 32'(Penable), 32'h1);
         tick();
         chk("t2_rspv", 32'(Rsp_valid), 32'(1 << own));
         chk("t2_rdata", Rsp_rdata, 32'h0);
         chk("t2_err", 32'(Rsp_err), 32'h0);
         tick();
      end
      Req_valid = '0;
      Pready    = 1'b0;

      // write with three wait states
      set_req(0, 1'b1, 1'b1, 32'h8800_0004, 32'hCAFE_F00D);
      #1;
      chk("t3_ready", 32'(Req_ready), 32'h1);
      tick();
      Req_valid = '0;
      chk("t3_setup_psel", 32'(Pselx), 32'h4);
      chk("t3_setup_pen", 32'(Penable), 32'h0);
      for (int j = 0; j < 4; j++) begin
         tick();
         chk("t3_acc_pen", 32'(Penable), 32'h1);
         chk("t3_acc_psel", 32'(Pselx), 32'h4);
         chk("t3_acc_paddr", Paddr, 32'h8800_0004);
         chk("t3_acc_pwdata", Pwdata, 32'hCAFE_F00D);
         chk("t3_acc_pwrite", 32'(Pwrite), 32'h1);
         chk("t3_acc_rspv", 32'(Rsp_valid), 32'h0);
         if (j == 3) Pready = 1'b1;
      end
      tick();
      Pready = 1'b0;
      chk("t3_rspv", 32'(Rsp_valid), 32'h1);
      chk("t3_err", 32'(Rsp_err), 32'h0);
      chk("t3_resp_pen", 32'(Penable), 32'h0);
      tick();

      // decode miss: pointer now 1, req1 alone
      set_req(1, 1'b1, 1'b0, 32'h9000_0000, 32'h0);
      #1;
      chk("t4a_ready", 32'(Req_ready), 32'h2);
      tick();
      Req_valid = '0;
      chk("t4a_rspv", 32'(Rsp_valid), 32'h2);
      chk("t4a_err", 32'(Rsp_err), 32'h1);
      chk("t4a_rdata", Rsp_rdata, 32'h0);
      chk("t4a_psel", 32'(Pselx), 32'h0);
      tick();
      chk("t4a_idle_rspv", 32'(Rsp_valid), 32'h0);
      chk("t4a_idle_psel", 32'(Pselx), 32'h0);

      // timeout after 16 ACCESS cycles
      set_req(0, 1'b1, 1'b0, 32'h8000_0020, 32'h0);
      Prdata = 32'h1234_5678;
      #1;
      chk("t4b_ready", 32'(Req_ready), 32'h1);
      tick();
      Req_valid = '0;
      for (int j = 0; j < 16; j++) begin
         tick();
         chk("t4b_acc_pen", 32'(Penable), 32'h1);
         chk("t4b_acc_rspv", 32'(Rsp_valid), 32'h0);
      end
      tick();
      chk("t4b_rspv", 32'(Rsp_valid), 32'h1);
      chk("t4b_err", 32'(Rsp_err), 32'h1);
      chk("t4b_rdata", Rsp_rdata, 32'h0);
      chk("t4b_pen", 32'(Penable), 32'h0);
      tick();

      // read with slave error still returns data
      set_req(1, 1'b1, 1'b0, 32'h8400_0008, 32'h0);
      Prdata  = 32'hA5A5_5A5A;
      Pready  = 1'b1;
      Pslverr = 1'b1;
      #1;
      chk("t4c_ready", 32'(Req_ready), 32'h2);
      tick();
      Req_valid = '0;
      chk("t4c_psel", 32'(Pselx), 32'h2);
      tick();
      tick();
      chk("t4c_rspv", 32'(Rsp_valid), 32'h2);
      chk("t4c_rdata", Rsp_rdata, 32'hA5A5_5A5A);
      chk("t4c_err", 32'(Rsp_err), 32'h1);
      Pready  = 1'b0;
      Pslverr = 1'b0;
      tick();

      // reset pulsed in ACCESS
      set_req(0, 1'b1, 1'b0, 32'h8000_0000, 32'h0);
      #1;
      chk("t5_ready", 32'(Req_ready), 32'h1);
      tick();
      Req_valid = '0;
      tick();
      chk("t5_acc_pen", 32'(Penable), 32'h1);
      Hreset = 1'b1;
      tick();
      Hreset = 1'b0;
      chk_idle_outs("t5_rst");
      tick();
      chk("t5_post_rspv", 32'(Rsp_valid), 32'h0);
      set_req(0, 1'b1, 1'b0, 32'h8000_0000, 32'h0);
      set_req(1, 1'b1, 1'b0, 32'h8000_0100, 32'h0);
      #1;
      chk("t5_ptr0_ready", 32'(Req_ready), 32'h1);
      Req_valid[0] = 1'b0;
      #1;
      chk("t5_req1_ready", 32'(Req_ready), 32'h2);
      tick();
      Req_valid = '0;
      Pready    = 1'b1;
      Prdata    = 32'h0BAD_F00D;
      chk("t5_setup_psel", 32'(Pselx), 32'h1);
      chk("t5_setup_paddr", Paddr, 32'h8000_0100);
      tick();
      chk("t5_acc_pen", 32'(Penable), 32'h1);
      tick();
      chk("t5_rspv", 32'(Rsp_valid), 32'h2);
      chk("t5_rdata", Rsp_rdata, 32'h0BAD_F00D);
      chk("t5_err", 32'(Rsp_err), 32'h0);
      Pready = 1'b0;
      tick();
      chk("t5_idle_rspv", 32'(Rsp_valid), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
